// File: rtl/seq_mult_pkg.sv
// Shared definitions for the seq_mult_hs shift-add multiplier: state width,
// state encodings and the state type used by the controller.
package seq_mult_pkg;

  localparam int STATE_W = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE = 2'b00;
  localparam state_t S_RUN  = 2'b01;
  localparam state_t S_DONE = 2'b10;

endpackage

// File: rtl/seq_mult_hs_if.sv
// Operand/product handshake bundle for seq_mult_hs; the producer/consumer side
// uses the master modport, the multiplier uses the slave modport.
interface seq_mult_hs_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic                 busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product, busy
  );
endinterface

// File: rtl/seq_mult_dp.sv
// Shift-add datapath: multiplicand, multiplier shift register and accumulator.
// With SEQ_MULT_EARLY_TERM_EN defined, an all-zero multiplier flushes the acc.
module seq_mult_dp #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_EARLY_TERM_EN
  input  logic [CNT_W:0]       rem,
  output logic                 mplier_zero,
`endif
  output logic [2*WIDTH-1:0]   acc
);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign mplier_zero = (mplier == '0);
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= a;
      mplier <= b;
    end else if (step) begin
`ifdef SEQ_MULT_EARLY_TERM_EN
      if (mplier_zero) begin
        // No set bits remain: apply every outstanding doubling at once.
        acc <= acc << rem;
      end else
`endif
      begin
        acc    <= (acc << 1) + (mplier[WIDTH-1] ? {{WIDTH{1'b0}}, mcand} : '0);
        mplier <= mplier << 1;
      end
    end
  end

endmodule

// File: rtl/seq_mult_hs.sv
// Unsigned sequential multiplier, one multiplier bit per cycle MSB first, with
// valid/ready on operands and product. Optional macro: SEQ_MULT_EARLY_TERM_EN.
module seq_mult_hs
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_mult_hs_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic               load;
  logic               step;
  logic               last_step;
  logic [2*WIDTH-1:0] acc;

`ifdef SEQ_MULT_EARLY_TERM_EN
  logic               mplier_zero;
  logic [CNT_W:0]     rem;

  assign rem       = (CNT_W+1)'(WIDTH) - {1'b0, cnt};
  assign last_step = (cnt == LAST) || mplier_zero;
`else
  assign last_step = (cnt == LAST);
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          load       = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        step = 1'b1;
        if (last_step) state_next = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (load)      cnt <= '0;
      else if (step) cnt <= cnt + CNT_W'(1);
    end
  end

  seq_mult_dp #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .step        (step),
    .a           (bus.in_a),
    .b           (bus.in_b),
`ifdef SEQ_MULT_EARLY_TERM_EN
    .rem         (rem),
    .mplier_zero (mplier_zero),
`endif
    .acc         (acc)
  );

  assign bus.in_ready    = (state == S_IDLE);
  assign bus.out_valid   = (state == S_DONE);
  assign bus.busy        = (state == S_RUN) || (state == S_DONE);
  assign bus.out_product = acc;

endmodule

// File: tb/tb_seq_mult_hs.sv
// Directed plus random checks of seq_mult_hs against a plain-arithmetic model
// of product value and latency (both with and without early termination).
module tb_seq_mult_hs;

  localparam int WIDTH = 8;
  localparam int MAX_WAIT = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  seq_mult_hs_if #(.WIDTH(WIDTH)) bus ();

  seq_mult_hs #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Cycles from the accepting edge until out_valid, derived from which
  // multiplier bits still have to be examined.
  function automatic int ref_latency(input logic [WIDTH-1:0] b);
`ifdef SEQ_MULT_EARLY_TERM_EN
    int k;
    k = 0;
    for (int i = 0; i < WIDTH; i++) if (b[i]) begin k = WIDTH - i; break; end
    return (k == WIDTH) ? WIDTH : k + 1;
`else
    return WIDTH;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair, wait for the product, optionally stall the
  // consumer for 'hold' cycles, then hand off and check return to idle.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input int hold);
    int cycles;
    logic [2*WIDTH-1:0] exp_p;
    exp_p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    cycles = 0;
    while (!bus.in_ready && cycles < MAX_WAIT) begin tick(); cycles++; end
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = (hold == 0);
    tick();
    bus.in_valid = 1'b0;
    bus.in_a     = ~a;
    bus.in_b     = ~b;
    check({tag, " busy_run"}, 32'(bus.busy), 32'd1);
    check({tag, " in_ready_run"}, 32'(bus.in_ready), 32'd0);
    cycles = 0;
    while (!bus.out_valid && cycles < MAX_WAIT) begin tick(); cycles++; end
    check({tag, " latency"}, 32'(cycles), 32'(ref_latency(b)));
    check({tag, " product"}, 32'(bus.out_product), 32'(exp_p));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, " hold_product"}, 32'(bus.out_product), 32'(exp_p));
      check({tag, " hold_in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " idle_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, " idle_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int cycles;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    #2;
    check("rst in_ready", 32'(bus.in_ready), 32'd1);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst product", 32'(bus.out_product), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    run_op("13x11", 8'd13, 8'd11, 0);
    run_op("255x255", 8'd255, 8'd255, 0);
    run_op("0x200", 8'd0, 8'd200, 0);
    run_op("1x1", 8'd1, 8'd1, 0);
    run_op("bp_6x7", 8'd6, 8'd7, 5);
    run_op("10x80", 8'd10, 8'h80, 0);
    run_op("10x0", 8'd10, 8'h00, 1);
    run_op("10x01", 8'd10, 8'h01, 0);

    // in_valid held through RUN with new operands: they wait for IDLE.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 8'd3;
    bus.in_b      = 8'd4;
    tick();
    bus.in_a = 8'd5;
    bus.in_b = 8'd5;
    cycles = 0;
    while (!bus.out_valid && cycles < MAX_WAIT) begin tick(); cycles++; end
    check("inorder first_lat", 32'(cycles), 32'(ref_latency(8'd4)));
    check("inorder first", 32'(bus.out_product), 32'd12);
    tick();
    check("inorder idle", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("inorder second_accept", 32'(bus.busy), 32'd1);
    cycles = 0;
    while (!bus.out_valid && cycles < MAX_WAIT) begin tick(); cycles++; end
    check("inorder second", 32'(bus.out_product), 32'd25);
    tick();
    bus.out_ready = 1'b0;

    // Asynchronous reset in the middle of a run.
    bus.in_valid = 1'b1;
    bus.in_a     = 8'd200;
    bus.in_b     = 8'd255;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    check("pre_rst busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst busy", 32'(bus.busy), 32'd0);
    check("mid_rst product", 32'(bus.out_product), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("9x9", 8'd9, 8'd9, 0);

    for (int i = 0; i < 25; i++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      if (i % 5 == 0) rb = rb & 8'hF0;
      run_op($sformatf("rand%0d", i), ra, rb, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
